// File: rtl/spi_flash_xfer.sv
// SPI flash transfer engine: one transaction = optional write, dummy and read phases
// over 1, 2 or 4 data lanes, SPI mode 0, with abort and a minimum CS-high gap.
module spi_flash_xfer #(
  parameter int CLK_DIV      = 1,
  parameter int MAX_WR_BYTES = 260,
  parameter int MAX_RD_BYTES = 8,
  localparam int WW = $clog2(MAX_WR_BYTES + 1),
  localparam int RW = $clog2(MAX_RD_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      trigger,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  input  logic [1:0]                mode,
  input  logic                      cmd_single,
  input  logic [WW-1:0]             wr_count,
  input  logic [RW-1:0]             rd_count,
  input  logic [4:0]                dummy_cycles,
  input  logic [MAX_WR_BYTES*8-1:0] data_in,
  output logic [MAX_RD_BYTES*8-1:0] data_out,
  output logic                      sck,
  output logic                      cs_n,
  output logic [3:0]                dq_o,
  output logic [3:0]                dq_oe,
  input  logic [3:0]                dq_i
);
  localparam int TXW = MAX_WR_BYTES * 8;
  localparam int RXW = MAX_RD_BYTES * 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEND   = 3'd1;
  localparam logic [2:0] DUMMY  = 3'd2;
  localparam logic [2:0] READ   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [WW-1:0] WR_MAX      = WW'(MAX_WR_BYTES);
  localparam logic [RW-1:0] RD_MAX      = RW'(MAX_RD_BYTES);
  localparam logic [WW+2:0] WR_FULL     = (WW + 3)'(TXW);
  localparam logic [7:0]    DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [8:0]    FIN_LAST    = 9'(2 * CLK_DIV);

  logic [2:0]    state_reg;
  logic [1:0]    mode_reg;       // lane count is 1 << mode_reg
  logic [3:0]    cmd_left_reg;   // single-lane command beats still to send
  logic [WW+2:0] wr_bits_reg;
  logic [RW+2:0] rd_bits_reg;
  logic [4:0]    dummy_reg;
  logic [TXW-1:0] tx_reg;
  logic [RXW-1:0] rx_reg;
  logic [7:0]    div_reg;
  logic [8:0]    fin_reg;
  logic          sck_reg, cs_n_reg, done_reg;

  logic [WW-1:0] wr_clamp;
  logic [RW-1:0] rd_clamp;
  logic [1:0]    mode_norm;
  logic [2:0]    rd_lanes, tx_lanes;
  logic          tick, sck_rise, sck_fall, last_beat;
  logic [2:0]    start_state, after_send, after_dummy, next_phase;

  always_comb begin
    wr_clamp    = (wr_count > WR_MAX) ? WR_MAX : wr_count;
    rd_clamp    = (rd_count > RD_MAX) ? RD_MAX : rd_count;
    mode_norm   = (mode == 2'd3) ? 2'd0 : mode;
    rd_lanes    = 3'd1 << mode_reg;
    tx_lanes    = (cmd_left_reg != 4'd0) ? 3'd1 : rd_lanes;
    tick        = (div_reg == DIV_LAST);
    sck_rise    = tick && !sck_reg;
    sck_fall    = tick && sck_reg;
    after_dummy = (rd_bits_reg != '0) ? READ : FINISH;
    after_send  = (dummy_reg != 5'd0) ? DUMMY : after_dummy;
    start_state = (wr_clamp != '0) ? SEND :
                  (dummy_cycles != 5'd0) ? DUMMY :
                  (rd_clamp != '0) ? READ : FINISH;
    last_beat   = 1'b0;
    next_phase  = FINISH;
    case (state_reg)
      SEND: begin
        last_beat  = (wr_bits_reg == {{WW{1'b0}}, tx_lanes});
        next_phase = after_send;
      end
      DUMMY: begin
        last_beat  = (dummy_reg == 5'd1);
        next_phase = after_dummy;
      end
      READ: last_beat = (rd_bits_reg == {{RW{1'b0}}, rd_lanes});
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      mode_reg     <= 2'd0;
      cmd_left_reg <= 4'd0;
      wr_bits_reg  <= '0;
      rd_bits_reg  <= '0;
      dummy_reg    <= 5'd0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      div_reg      <= 8'd0;
      fin_reg      <= 9'd0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (trigger) begin
          mode_reg     <= mode_norm;
          cmd_left_reg <= (cmd_single && wr_clamp != '0) ? 4'd8 : 4'd0;
          wr_bits_reg  <= {wr_clamp, 3'b000};
          rd_bits_reg  <= {rd_clamp, 3'b000};
          dummy_reg    <= dummy_cycles;
          // left-justify so the first bit to send is always the MSB
          tx_reg       <= data_in << (WR_FULL - {wr_clamp, 3'b000});
          rx_reg       <= '0;
          div_reg      <= 8'd0;
          fin_reg      <= 9'd0;
          sck_reg      <= 1'b0;
          state_reg    <= start_state;
          cs_n_reg     <= (start_state == FINISH);
          done_reg     <= (start_state == FINISH);
        end
        SEND, DUMMY, READ: begin
          if (abort && !(sck_fall && last_beat)) begin
            state_reg <= FINISH;
            sck_reg   <= 1'b0;
            cs_n_reg  <= 1'b1;
            done_reg  <= 1'b1;
            fin_reg   <= 9'd0;
          end else begin
            div_reg <= tick ? 8'd0 : div_reg + 8'd1;
            if (tick) sck_reg <= !sck_reg;
            if (sck_rise && state_reg == READ) begin
              case (mode_reg)
                2'd0:    rx_reg <= {rx_reg[RXW-2:0], dq_i[1]};
                2'd1:    rx_reg <= {rx_reg[RXW-3:0], dq_i[1:0]};
                default: rx_reg <= {rx_reg[RXW-5:0], dq_i};
              endcase
            end
            if (sck_fall) begin
              case (state_reg)
                SEND: begin
                  tx_reg      <= tx_reg << tx_lanes;
                  wr_bits_reg <= wr_bits_reg - {{WW{1'b0}}, tx_lanes};
                  if (cmd_left_reg != 4'd0) cmd_left_reg <= cmd_left_reg - 4'd1;
                end
                DUMMY:   dummy_reg   <= dummy_reg - 5'd1;
                default: rd_bits_reg <= rd_bits_reg - {{RW{1'b0}}, rd_lanes};
              endcase
              if (last_beat) begin
                state_reg <= next_phase;
                if (next_phase == FINISH) begin
                  cs_n_reg <= 1'b1;
                  done_reg <= 1'b1;
                  fin_reg  <= 9'd0;
                end
              end
            end
          end
        end
        FINISH: begin
          if (fin_reg == FIN_LAST) state_reg <= IDLE;
          else fin_reg <= fin_reg + 9'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // WP#/HOLD# stay driven high except while quad mode owns all four lanes
  always_comb begin
    dq_o  = 4'b1111;
    dq_oe = 4'b1100;
    case (state_reg)
      SEND: begin
        dq_oe = (mode_reg == 2'd0) ? 4'b1101 : 4'b1111;
        case (tx_lanes)
          3'd1:    dq_o[0]   = tx_reg[TXW-1];
          3'd2:    dq_o[1:0] = tx_reg[TXW-1 -: 2];
          default: dq_o      = tx_reg[TXW-1 -: 4];
        endcase
      end
      DUMMY, READ, FINISH: if (mode_reg == 2'd2) dq_oe = 4'b0000;
      default: ;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign sck      = sck_reg;
  assign cs_n     = cs_n_reg;
  assign data_out = rx_reg;
endmodule
